sba_preload_seq: RTL and testbench
==================================

// Module: sba_preload_seq
// PURPOSE
//  Hardware sequencer that preloads a RISC-V debug module's system-bus (SBA) target via DMI.
//  It replaces the JTAG-driven bench loop for the secure-domain Ibex SRAM. The loop was:
//  activate DM, write SBCS, write SBAddress0, then stream SBData0 with a sbbusy poll per word.
//  Sits between a word source (boot DMA / flash reader) and the DM's DMI request/response port.
// PARAMETERS
//  NumWordsW    16    width of word count and progress counter
//  PollTimeout  1024  max consecutive SBCS reads with sbbusy=1 before abort
// PORTS
//  clk              in   1   system clock
//  rst_n            in   1   reset; asynchronous, active-low
//  start_i          in   1   1-cycle pulse: launch preload (ignored while busy_o)
//  base_addr_i      in   32  SBA byte address of first word; sampled on start_i
//  num_words_i      in   NumWordsW  32-bit words to write; sampled on start_i
//  wdata_valid_i    in   1   word source valid
//  wdata_i          in   32  word data
//  wdata_ready_o    out  1   word accepted when valid&ready
//  dmi_req_valid_o  out  1   DMI request valid
//  dmi_req_ready_i  in   1   DMI request accepted
//  dmi_req_addr_o   out  7   DM register address
//  dmi_req_op_o     out  2   0 nop, 1 read, 2 write
//  dmi_req_data_o   out  32  write data
//  dmi_rsp_valid_i  in   1   DMI response valid
//  dmi_rsp_ready_o  out  1   response consumed
//  dmi_rsp_data_i   in   32  read data
//  dmi_rsp_resp_i   in   2   0 ok, 2 failed, 3 busy
//  busy_o           out  1   sequence in progress
//  done_o           out  1   1-cycle pulse on successful completion
//  err_o            out  1   sticky until next start_i
//  err_code_o       out  3   0 none,1 misaligned,2 dmi fail,3 poll timeout,4 sberror,5 sbbusyerror
//  words_done_o     out  NumWordsW  words confirmed written (post-poll)
// BEHAVIOUR
//  Reset: all outputs 0 except dmi_rsp_ready_o=1; FSM IDLE; counters 0.
//  DMI: one outstanding request max. req fields stable while valid & !ready.
//   rsp_ready_o=1 only in RSP states and IDLE; IDLE drains stray rsps.
//  FSM: IDLE -> ACT (W DMControl 0x10 = 0x0000_0001) -> CFG (W SBCS 0x38 = 0x0045_7000:
//   sbaccess=2, autoinc=1, W1C sberror/sbbusyerror) -> POLL -> ADDR (W SBAddress0 0x39)
//   -> POLL -> WAITD -> DATA (W SBData0 0x3C) -> POLL -> WAITD | DONE -> IDLE.
//   Each req state has a paired RSP sub-state.
//  WAITD: wdata_ready_o=1 for exactly that cycle window; word latched on handshake, no skid.
//  POLL: read SBCS; bit21 sbbusy=1 -> re-read next cycle, ++poll_cnt;
//   poll_cnt==PollTimeout -> ERR code 3. sbbusy=0 -> clear poll_cnt, advance.
//   After a DATA poll, ++words_done_o.
//  resp=3: re-issue identical request, no counter change. resp=2 -> ERR code 2 (any state).
//  start_i: base_addr_i[1:0]!=0 -> ERR code 1 next cycle, no DMI traffic.
//   num_words_i==0 -> done_o next cycle, no DMI traffic.
//  ERR: err_o=1, busy_o=0, return IDLE; pending word source untouched.
//  Minimum per-word cost with 1-cycle DMI: 1 (WAITD) + 2 (W req/rsp) + 2 (R req/rsp).
//  words_done_o saturates at num_words; no wrap (count <= 2^NumWordsW-1 by width).
//  Async reset mid-sequence: abort immediately, DM state left as is; next start re-runs ACT/CFG.
// CONFIGURATION
//  SBA_PRELOAD_ERRCHK_EN defined: every POLL also checks SBCS[14:12] sberror!=0 -> ERR code 4.
//   SBCS[22] sbbusyerror=1 -> ERR code 5 (checked before sbbusy).
//  Undefined: those bits ignored; codes 4/5 never produced.
// STRUCTURE
//  sba_preload_pkg: state enum, DMI addr consts (DMControl/SBCS/SBAddress0/SBData0),
//   SBCS_CFG value, dmi op/resp enums, err code enum, SBCS bit positions.
//  Sub-module sba_preload_dmi_xact: issues one DMI req, waits rsp, auto-retries on resp=3;
//   reports ok/fail/rdata to the FSM.
// TESTING
//  start base=0x1000_0000 n=4, ideal DMI, sbbusy=0 -> writes 0x10,0x38,0x39,4x0x3C in order;
//   SBCS reads interleaved; done_o once; words_done_o=4.
//  sbbusy=1 for 3 reads after word 2 -> 3 extra SBCS reads, no extra data write;
//   words_done_o=4 at end.
//  sbbusy stuck 1, PollTimeout=8 -> ERR code 3 after 8 polls; busy_o=0; no further req.
//  resp=3 twice on SBAddress0 write -> same req reissued 3x; resp=2 on data -> err code 2.
//  base=0x1000_0002 -> err code 1, zero DMI reqs; n=0 -> done_o next cycle, zero reqs.
//  ERRCHK_EN: sberror=3 on word 1 poll -> err code 4; without macro: completes, done_o.

Source files
------------

// File: rtl/sba_preload_pkg.sv
// sba_preload_pkg: FSM states, DM register map, DMI encodings and error codes for the SBA preloader
package sba_preload_pkg;
  typedef enum logic [3:0] {
    S_IDLE,
    S_ACT,
    S_CFG,
    S_POLL_CFG,
    S_ADDR,
    S_POLL_ADDR,
    S_WAITD,
    S_DATA,
    S_POLL_DATA,
    S_DONE
  } state_e;
  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2
  } dmi_op_e;
  typedef enum logic [1:0] {
    RSP_OK   = 2'd0,
    RSP_FAIL = 2'd2,
    RSP_BUSY = 2'd3
  } dmi_resp_e;
  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_MISALIGN  = 3'd1,
    ERR_DMI       = 3'd2,
    ERR_TIMEOUT   = 3'd3,
    ERR_SBERROR   = 3'd4,
    ERR_SBBUSYERR = 3'd5
  } err_code_e;
  localparam logic [6:0] ADDR_DMCONTROL = 7'h10;
  localparam logic [6:0] ADDR_SBCS = 7'h38;
  localparam logic [6:0] ADDR_SBADDR0 = 7'h39;
  localparam logic [6:0] ADDR_SBDATA0 = 7'h3C;
  localparam logic [31:0] DMCONTROL_ACT = 32'h0000_0001;
  // sbaccess=32-bit, autoincrement, and W1C of any stale sberror/sbbusyerror
  localparam logic [31:0] SBCS_CFG = 32'h0045_7000;
  localparam int SBCS_SBBUSYERROR = 22;
  localparam int SBCS_SBBUSY = 21;
  localparam int SBCS_SBERR_HI = 14;
  localparam int SBCS_SBERR_LO = 12;
endpackage

// File: rtl/sba_preload_dmi_xact.sv
// sba_preload_dmi_xact: one outstanding DMI request; re-issues the same request on a busy response
module sba_preload_dmi_xact
  import sba_preload_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [6:0]  addr,
  input  logic [1:0]  op,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        fail,
  output logic [31:0] rdata,
  output logic        dmi_req_valid,
  input  logic        dmi_req_ready,
  output logic [6:0]  dmi_req_addr,
  output logic [1:0]  dmi_req_op,
  output logic [31:0] dmi_req_data,
  input  logic        dmi_rsp_valid,
  output logic        dmi_rsp_ready,
  input  logic [31:0] dmi_rsp_data,
  input  logic [1:0]  dmi_rsp_resp
);
  logic wait_rsp;
  logic rsp_hs;
  assign dmi_req_valid = req & ~wait_rsp;
  assign dmi_req_addr = addr;
  assign dmi_req_op = op;
  assign dmi_req_data = wdata;
  assign dmi_rsp_ready = wait_rsp;
  assign rsp_hs = wait_rsp & dmi_rsp_valid;
  assign done = rsp_hs & (dmi_rsp_resp != RSP_BUSY);
  assign fail = dmi_rsp_resp != RSP_OK;
  assign rdata = dmi_rsp_data;
  // a busy response drops back to the request phase with the caller's fields unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_rsp <= 1'b0;
    else if (dmi_req_valid & dmi_req_ready) wait_rsp <= 1'b1;
    else if (rsp_hs) wait_rsp <= 1'b0;
  end
endmodule

// File: rtl/sba_preload_seq.sv
// sba_preload_seq: preloads SBA memory through the DM's DMI port from a word stream
// SBA_PRELOAD_ERRCHK_EN: also abort on SBCS sberror / sbbusyerror during polls
module sba_preload_seq
  import sba_preload_pkg::*;
#(
  parameter int NumWordsW = 16,
  parameter int PollTimeout = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [NumWordsW-1:0] num_words_i,
  input  logic                 wdata_valid_i,
  input  logic [31:0]          wdata_i,
  output logic                 wdata_ready_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [6:0]           dmi_req_addr_o,
  output logic [1:0]           dmi_req_op_o,
  output logic [31:0]          dmi_req_data_o,
  input  logic                 dmi_rsp_valid_i,
  output logic                 dmi_rsp_ready_o,
  input  logic [31:0]          dmi_rsp_data_i,
  input  logic [1:0]           dmi_rsp_resp_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [2:0]           err_code_o,
  output logic [NumWordsW-1:0] words_done_o
);
  localparam int PW = $clog2(PollTimeout) + 1;
  state_e state_q, state_d;
  err_code_e code_q, code_d, ec;
  logic [31:0] base_q, word_q, x_data, x_rdata;
  logic [NumWordsW-1:0] num_q, words_q, words_d;
  logic [PW-1:0] poll_q, poll_d;
  logic err_q, err_d;
  logic x_req, is_poll, x_done, x_fail, x_rsp_ready, unused_rdata;
  logic [6:0] x_addr;
  logic [1:0] x_op;
  assign is_poll = state_q inside {S_POLL_CFG, S_POLL_ADDR, S_POLL_DATA};
  assign x_req = is_poll | (state_q inside {S_ACT, S_CFG, S_ADDR, S_DATA});
  assign x_addr = is_poll ? ADDR_SBCS :
                  state_q == S_ACT ? ADDR_DMCONTROL :
                  state_q == S_CFG ? ADDR_SBCS :
                  state_q == S_ADDR ? ADDR_SBADDR0 :
                  state_q == S_DATA ? ADDR_SBDATA0 : 7'd0;
  assign x_op = is_poll ? DMI_READ : x_req ? DMI_WRITE : DMI_NOP;
  assign x_data = state_q == S_ACT ? DMCONTROL_ACT :
                  state_q == S_CFG ? SBCS_CFG :
                  state_q == S_ADDR ? base_q :
                  state_q == S_DATA ? word_q : 32'd0;
  assign unused_rdata = ^x_rdata;
  sba_preload_dmi_xact u_xact (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (x_req),
    .addr          (x_addr),
    .op            (x_op),
    .wdata         (x_data),
    .done          (x_done),
    .fail          (x_fail),
    .rdata         (x_rdata),
    .dmi_req_valid (dmi_req_valid_o),
    .dmi_req_ready (dmi_req_ready_i),
    .dmi_req_addr  (dmi_req_addr_o),
    .dmi_req_op    (dmi_req_op_o),
    .dmi_req_data  (dmi_req_data_o),
    .dmi_rsp_valid (dmi_rsp_valid_i),
    .dmi_rsp_ready (x_rsp_ready),
    .dmi_rsp_data  (dmi_rsp_data_i),
    .dmi_rsp_resp  (dmi_rsp_resp_i)
  );
  // IDLE keeps rsp_ready high so stray responses are drained
  assign dmi_rsp_ready_o = x_rsp_ready | (state_q == S_IDLE);
  assign wdata_ready_o = state_q == S_WAITD;
  assign busy_o = state_q != S_IDLE;
  assign done_o = state_q == S_DONE;
  assign err_o = err_q;
  assign err_code_o = code_q;
  assign words_done_o = words_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      code_q <= ERR_NONE;
      err_q <= 1'b0;
      base_q <= '0;
      num_q <= '0;
      word_q <= '0;
      words_q <= '0;
      poll_q <= '0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      err_q <= err_d;
      words_q <= words_d;
      poll_q <= poll_d;
      if (state_q == S_IDLE && start_i) begin
        base_q <= base_addr_i;
        num_q <= num_words_i;
      end
      if (state_q == S_WAITD && wdata_valid_i) word_q <= wdata_i;
    end
  end
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    err_d = err_q;
    words_d = words_q;
    poll_d = poll_q;
    ec = ERR_NONE;
    case (state_q)
      S_IDLE: if (start_i) begin
        err_d = 1'b0;
        code_d = ERR_NONE;
        words_d = '0;
        poll_d = '0;
        if (base_addr_i[1:0] != 2'b00) ec = ERR_MISALIGN;
        else state_d = (num_words_i == '0) ? S_DONE : S_ACT;
      end
      S_ACT, S_CFG, S_ADDR, S_DATA: if (x_done) begin
        if (x_fail) ec = ERR_DMI;
        else state_d = state_q == S_ACT ? S_CFG :
                       state_q == S_CFG ? S_POLL_CFG :
                       state_q == S_ADDR ? S_POLL_ADDR : S_POLL_DATA;
      end
      S_POLL_CFG, S_POLL_ADDR, S_POLL_DATA: if (x_done) begin
        if (x_fail) ec = ERR_DMI;
`ifdef SBA_PRELOAD_ERRCHK_EN
        else if (x_rdata[SBCS_SBBUSYERROR]) ec = ERR_SBBUSYERR;
        else if (x_rdata[SBCS_SBERR_HI:SBCS_SBERR_LO] != 3'd0) ec = ERR_SBERROR;
`endif
        else if (x_rdata[SBCS_SBBUSY]) begin
          if (poll_q == PW'(PollTimeout - 1)) ec = ERR_TIMEOUT;
          else poll_d = poll_q + PW'(1);
        end else begin
          poll_d = '0;
          if (state_q == S_POLL_CFG) state_d = S_ADDR;
          else if (state_q == S_POLL_ADDR) state_d = S_WAITD;
          else begin
            words_d = (words_q == num_q) ? words_q : words_q + NumWordsW'(1);
            state_d = (words_q + NumWordsW'(1) == num_q) ? S_DONE : S_WAITD;
          end
        end
      end
      S_WAITD: if (wdata_valid_i) state_d = S_DATA;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ec != ERR_NONE) begin
      state_d = S_IDLE;
      err_d = 1'b1;
      code_d = ec;
    end
  end
endmodule

// File: tb/tb_sba_preload_seq.sv
// tb_sba_preload_seq: directed checks of the SBA preload sequencer against a DMI responder model
`timescale 1ns/1ps
module tb_sba_preload_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic wdata_valid = 1'b0, wdata_ready;
  logic [31:0] wdata = '0;
  logic dmi_req_valid, dmi_req_ready = 1'b1, dmi_rsp_valid = 1'b0, dmi_rsp_ready;
  logic [6:0] dmi_req_addr;
  logic [1:0] dmi_req_op, dmi_rsp_resp = '0;
  logic [31:0] dmi_req_data, dmi_rsp_data = '0;
  logic busy, done, err;
  logic [2:0] err_code;
  logic [15:0] words_done;
  int n_chk = 0, n_err = 0;
  logic [6:0] log_addr [512];
  logic [1:0] log_op [512];
  logic [31:0] log_data [512];
  int n_req = 0, n_done = 0, widx = 0;
  int stuck = 0, busy_trig = -1, sberr_trig = -1, retry_upto = 0, fail_data = 0;
  int dw_total = 0, w39_total = 0, busy_left = 0;
  logic pend = 1'b0;
  logic [1:0] p_resp = '0;
  logic [31:0] p_data = '0;

  always #5 clk = ~clk;

  sba_preload_seq #(.NumWordsW(16), .PollTimeout(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base_addr), .num_words_i(num_words),
    .wdata_valid_i(wdata_valid), .wdata_i(wdata), .wdata_ready_o(wdata_ready),
    .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready), .dmi_req_addr_o(dmi_req_addr),
    .dmi_req_op_o(dmi_req_op), .dmi_req_data_o(dmi_req_data), .dmi_rsp_valid_i(dmi_rsp_valid),
    .dmi_rsp_ready_o(dmi_rsp_ready), .dmi_rsp_data_i(dmi_rsp_data), .dmi_rsp_resp_i(dmi_rsp_resp),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code), .words_done_o(words_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DMI target: ready always, response one cycle after each accepted request
  initial forever begin
    @(negedge clk);
    dmi_rsp_valid = 1'b0;
    dmi_rsp_resp = 2'd0;
    dmi_rsp_data = '0;
    if (pend) begin
      dmi_rsp_valid = 1'b1;
      dmi_rsp_resp = p_resp;
      dmi_rsp_data = p_data;
      pend = 1'b0;
    end else if (dmi_req_valid) begin
      log_addr[n_req] = dmi_req_addr;
      log_op[n_req] = dmi_req_op;
      log_data[n_req] = dmi_req_data;
      n_req++;
      p_resp = 2'd0;
      p_data = '0;
      if (dmi_req_op == 2'd1) begin
        p_data[21] = (stuck != 0) || (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (dw_total == sberr_trig) p_data[13:12] = 2'b11;
      end else if (dmi_req_addr == 7'h39) begin
        w39_total++;
        if (w39_total <= retry_upto) p_resp = 2'd3;
      end else if (dmi_req_addr == 7'h3C) begin
        dw_total++;
        if (dw_total == busy_trig) busy_left = 3;
        if (fail_data != 0) p_resp = 2'd2;
      end
      pend = 1'b1;
    end
  end

  initial begin
    wdata_valid = 1'b1;
    wdata = 32'hA000_0000;
    forever begin
      @(negedge clk);
      if (wdata_ready) begin
        @(posedge clk);
        #1;
        widx++;
        wdata = 32'hA000_0000 + widx;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) n_done++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic go(input logic [31:0] b, input logic [15:0] n);
    base_addr = b;
    num_words = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, " idle"}, busy, 1'b0);
  endtask

  initial begin
    int n0, w0, d0, rds;
    logic rd;
    logic [6:0] ea;
    logic [31:0] ed;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", {err, err_code}, 4'd0);
    check("rst words", words_done, 16'd0);
    check("rst req_valid", dmi_req_valid, 1'b0);
    check("rst req_op", {dmi_req_op, dmi_req_addr}, 9'd0);
    check("rst wready", wdata_ready, 1'b0);
    check("rst rsp_ready", dmi_rsp_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    n0 = n_req; w0 = widx; d0 = n_done;
    go(32'h1000_0000, 16'd4);
    wait_idle("t1", 300);
    check("t1 nreq", n_req - n0, 13);
    check("t1 done", n_done - d0, 1);
    check("t1 words", words_done, 4);
    check("t1 err", err, 1'b0);
    for (int i = 0; i < 13; i++) begin
      rd = (i > 0) && (i % 2 == 0);
      ea = rd ? 7'h38 : i == 0 ? 7'h10 : i == 1 ? 7'h38 : i == 3 ? 7'h39 : 7'h3C;
      ed = i == 0 ? 32'h1 : i == 1 ? 32'h0045_7000 : i == 3 ? 32'h1000_0000 : 32'hA000_0000 + w0 + (i - 5) / 2;
      check($sformatf("t1 req%0d addr", i), log_addr[n0 + i], ea);
      check($sformatf("t1 req%0d op", i), log_op[n0 + i], rd ? 2'd1 : 2'd2);
      if (!rd) check($sformatf("t1 req%0d data", i), log_data[n0 + i], ed);
    end

    n0 = n_req; d0 = n_done; busy_trig = dw_total + 2;
    go(32'h2000_0000, 16'd4);
    wait_idle("t2", 300);
    busy_trig = -1;
    rds = 0;
    for (int i = n0; i < n_req; i++) if (log_op[i] == 2'd1) rds++;
    check("t2 nreq", n_req - n0, 16);
    check("t2 reads", rds, 9);
    check("t2 words", words_done, 4);
    check("t2 done", n_done - d0, 1);

    n0 = n_req; d0 = n_done; stuck = 1;
    go(32'h3000_0000, 16'd2);
    wait_idle("t3", 300);
    stuck = 0;
    check("t3 err", {err, err_code}, {1'b1, 3'd3});
    check("t3 nreq", n_req - n0, 10);
    repeat (20) @(negedge clk);
    check("t3 quiet", n_req - n0, 10);
    check("t3 busy", busy, 1'b0);
    check("t3 done", n_done - d0, 0);

    n0 = n_req; w0 = widx; retry_upto = w39_total + 2; fail_data = 1;
    go(32'h4000_0000, 16'd2);
    wait_idle("t4", 300);
    fail_data = 0;
    check("t4 err", {err, err_code}, {1'b1, 3'd2});
    check("t4 nreq", n_req - n0, 8);
    for (int i = 3; i < 6; i++) begin
      check($sformatf("t4 retry%0d addr", i), log_addr[n0 + i], 7'h39);
      check($sformatf("t4 retry%0d data", i), log_data[n0 + i], 32'h4000_0000);
    end
    check("t4 data", log_data[n0 + 7], 32'hA000_0000 + w0);
    repeat (10) @(negedge clk);
    check("t4 src", widx - w0, 1);
    check("t4 wready", wdata_ready, 1'b0);

    n0 = n_req;
    go(32'h1000_0002, 16'd3);
    check("t5 err", {err, err_code}, {1'b1, 3'd1});
    check("t5 busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    check("t5 nreq", n_req - n0, 0);

    n0 = n_req;
    go(32'h5000_0000, 16'd0);
    check("t6 done", done, 1'b1);
    check("t6 err", err, 1'b0);
    @(negedge clk);
    check("t6 done pulse", done, 1'b0);
    check("t6 busy", busy, 1'b0);
    check("t6 nreq", n_req - n0, 0);

    n0 = n_req; d0 = n_done; sberr_trig = dw_total + 1;
    go(32'h6000_0000, 16'd2);
    wait_idle("t7", 300);
    sberr_trig = -1;
`ifdef SBA_PRELOAD_ERRCHK_EN
    check("t7 err", {err, err_code}, {1'b1, 3'd4});
    check("t7 nreq", n_req - n0, 7);
    check("t7 words", words_done, 0);
`else
    check("t7 err", err, 1'b0);
    check("t7 done", n_done - d0, 1);
    check("t7 words", words_done, 2);
`endif

    go(32'h7000_0000, 16'd3);
    repeat (3) @(negedge clk);
    check("t8 busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t8 rst busy", busy, 1'b0);
    check("t8 rst req", dmi_req_valid, 1'b0);
    check("t8 rst rsp_ready", dmi_rsp_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n0 = n_req; d0 = n_done;
    go(32'h7000_0000, 16'd1);
    wait_idle("t8", 300);
    check("t8 first", log_addr[n0], 7'h10);
    check("t8 nreq", n_req - n0, 7);
    check("t8 done", n_done - d0, 1);
    check("t8 words", words_done, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
